// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and byte-enable mask expansion for the register file family.
package regfile_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_ADDR_BITS = 5;
    localparam int DEF_NREAD = 2;
    localparam int MAX_BYTES = 32;
    localparam int MAX_WIDTH = MAX_BYTES * 8;

    // Callers zero-extend their enables to MAX_BYTES and truncate the mask back to their width.
    function automatic logic [MAX_WIDTH-1:0] bytemask(input logic [MAX_BYTES-1:0] be);
        logic [MAX_WIDTH-1:0] m;
        for (int k = 0; k < MAX_BYTES; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction
endpackage

// File: rtl/regfile_word.sv
// regfile_word: one storage word with async clear and two masked write inputs, B winning per bit.
module regfile_word #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_a_i,
    input  logic [WIDTH-1:0] mask_a_i,
    input  logic [WIDTH-1:0] data_a_i,
    input  logic             we_b_i,
    input  logic [WIDTH-1:0] mask_b_i,
    input  logic [WIDTH-1:0] data_b_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] d_o
);
    logic [WIDTH-1:0] q_q, q_d, ma, mb;

    assign ma = we_a_i ? mask_a_i : '0;
    assign mb = we_b_i ? mask_b_i : '0;
    assign q_d = (q_q & ~ma & ~mb) | (data_a_i & ma & ~mb) | (data_b_i & mb);
    assign q_o = q_q;
    assign d_o = q_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_q <= '0;
        else q_q <= q_d;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file, NREAD combinational reads and two
// byte-masked write ports with B-over-A collision priority and optional write-first bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int NREAD     = DEF_NREAD,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 0
) (
    input  logic                       Clk_i,
    input  logic                       Reset_i,
    input  logic [NREAD*ADDR_BITS-1:0] ReadRegister_i,
    output logic [NREAD*WIDTH-1:0]     ReadData_o,
    input  logic [ADDR_BITS-1:0]       WriteRegisterA_i,
    input  logic [WIDTH-1:0]           WriteDataA_i,
    input  logic                       RegWriteA_i,
    input  logic [WIDTH/8-1:0]         ByteEnA_i,
    input  logic [ADDR_BITS-1:0]       WriteRegisterB_i,
    input  logic [WIDTH-1:0]           WriteDataB_i,
    input  logic                       RegWriteB_i,
    input  logic [WIDTH/8-1:0]         ByteEnB_i
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] mask_a, mask_b;
    logic [WIDTH-1:0] cur [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];

    assign mask_a = WIDTH'(bytemask(MAX_BYTES'(ByteEnA_i)));
    assign mask_b = WIDTH'(bytemask(MAX_BYTES'(ByteEnB_i)));

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        if (ZERO_REG != 0 && w == 0) begin : g_zero
            assign cur[w] = '0;
            assign nxt[w] = '0;
        end else begin : g_reg
            regfile_word #(.WIDTH(WIDTH)) u_word (
                .clk_i    (Clk_i),
                .rst_i    (Reset_i),
                .we_a_i   (RegWriteA_i && WriteRegisterA_i == ADDR_BITS'(w)),
                .mask_a_i (mask_a),
                .data_a_i (WriteDataA_i),
                .we_b_i   (RegWriteB_i && WriteRegisterB_i == ADDR_BITS'(w)),
                .mask_b_i (mask_b),
                .data_b_i (WriteDataB_i),
                .q_o      (cur[w]),
                .d_o      (nxt[w])
            );
        end
    end

    // Each word's next-state value is exactly the write-first bypass result.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_BITS-1:0] ra;
        assign ra = ReadRegister_i[i*ADDR_BITS +: ADDR_BITS];
        assign ReadData_o[i*WIDTH +: WIDTH] = Reset_i ? '0 : (BYPASS != 0 ? nxt[ra] : cur[ra]);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of read-first and write-first regfile_mp against a byte-level model.
module tb_regfile_mp;
    import regfile_pkg::*;
    localparam int W = DEF_WIDTH, AB = 5, NR = 4, D = 32;

    logic clk = 1'b0, rst;
    logic [NR*AB-1:0] ra;
    logic [NR*W-1:0] rd_rf, rd_wf;
    logic [AB-1:0] wa_a, wa_b;
    logic [W-1:0] da, db;
    logic we_a, we_b;
    logic [W/8-1:0] be_a, be_b;
    logic [W-1:0] mem [D];
    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(W), .ADDR_BITS(AB), .NREAD(NR), .ZERO_REG(1), .BYPASS(0)) dut_rf (
        .Clk_i(clk), .Reset_i(rst), .ReadRegister_i(ra), .ReadData_o(rd_rf),
        .WriteRegisterA_i(wa_a), .WriteDataA_i(da), .RegWriteA_i(we_a), .ByteEnA_i(be_a),
        .WriteRegisterB_i(wa_b), .WriteDataB_i(db), .RegWriteB_i(we_b), .ByteEnB_i(be_b));

    regfile_mp #(.WIDTH(W), .ADDR_BITS(AB), .NREAD(NR), .ZERO_REG(1), .BYPASS(1)) dut_wf (
        .Clk_i(clk), .Reset_i(rst), .ReadRegister_i(ra), .ReadData_o(rd_wf),
        .WriteRegisterA_i(wa_a), .WriteDataA_i(da), .RegWriteA_i(we_a), .ByteEnA_i(be_a),
        .WriteRegisterB_i(wa_b), .WriteDataB_i(db), .RegWriteB_i(we_b), .ByteEnB_i(be_b));

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Value address a will hold after the coming edge, built byte by byte from the priority rules.
    function automatic logic [W-1:0] model_next(input logic [AB-1:0] a);
        logic [W-1:0] v;
        v = mem[a];
        if (a == 0) return '0;
        for (int k = 0; k < W/8; k++) begin
            if (we_b && wa_b == a && be_b[k]) v[8*k +: 8] = db[8*k +: 8];
            else if (we_a && wa_a == a && be_a[k]) v[8*k +: 8] = da[8*k +: 8];
        end
        return v;
    endfunction

    task automatic set_rst(input logic r);
        rst = r;
        if (r) for (int a = 0; a < D; a++) mem[a] = '0;
    endtask

    task automatic check_ports(input string tag);
        logic [AB-1:0] a;
        for (int i = 0; i < NR; i++) begin
            a = ra[i*AB +: AB];
            check($sformatf("%s rf p%0d a%0d", tag, i, a), rd_rf[i*W +: W], rst ? '0 : mem[a]);
            check($sformatf("%s wf p%0d a%0d", tag, i, a), rd_wf[i*W +: W], rst ? '0 : model_next(a));
        end
    endtask

    task automatic step(input string tag);
        logic [W-1:0] nv [D];
        #1 check_ports(tag);
        @(posedge clk);
        if (!rst) begin
            for (int a = 0; a < D; a++) nv[a] = model_next(AB'(a));
            for (int a = 0; a < D; a++) mem[a] = nv[a];
        end
        @(negedge clk);
    endtask

    task automatic idle();
        we_a = 0; we_b = 0; be_a = '1; be_b = '1;
    endtask

    task automatic wr_a(input logic [AB-1:0] a, input logic [W-1:0] d, input string tag);
        idle(); we_a = 1; wa_a = a; da = d;
        step(tag);
    endtask

    task automatic read_all(input logic [AB-1:0] a);
        for (int i = 0; i < NR; i++) ra[i*AB +: AB] = a;
    endtask

    initial begin
        idle(); wa_a = 0; wa_b = 0; da = 0; db = 0; ra = '0;
        set_rst(1);
        // write attempted across a reset edge must not land
        we_a = 1; wa_a = 4; da = 32'hDEADBEEF; read_all(4);
        step("rst_prio");
        set_rst(0); idle();
        #1 check("rst_prio reg4", rd_rf[0 +: W], '0);
        step("post_rst");
        for (int r = 1; r < D; r++) wr_a(AB'(r), W'(r * 10), "walk_wr");
        for (int r = 0; r < D; r++) begin
            read_all(AB'(r));
            #1 check($sformatf("walk r%0d", r), rd_rf[3*W +: W], W'(r * 10));
            step("walk_rd");
        end
        // asynchronous clear is visible before any clock edge
        set_rst(1); read_all(17);
        #1 check("async clr", rd_wf[W +: W], '0);
        step("rst2");
        set_rst(0);
        wr_a(2, 15, "en_wr");
        idle(); wa_a = 2; da = 42; read_all(2);
        step("en_off");
        #1 check("en_off reg2", rd_rf[0 +: W], 15);
        wr_a(2, 100, "en_100");
        for (int r = 0; r < D; r++) begin
            read_all(AB'(r));
            #1 check($sformatf("dec r%0d", r), rd_rf[W +: W], r == 2 ? 100 : 0);
        end
        wr_a(5, 32'h11223344, "col_init");
        idle(); we_a = 1; we_b = 1; wa_a = 5; wa_b = 5;
        da = 32'hAAAAAAAA; db = 32'hBBBBBBBB; be_a = 4'b0011; be_b = 4'b0110; read_all(5);
        #1 check("col bypass", rd_wf[0 +: W], 32'h11BBBBAA);
        step("col");
        check("col stored", rd_rf[2*W +: W], 32'h11BBBBAA);
        wr_a(17, 100, "ind"); wr_a(3, 7, "ind"); wr_a(9, 8, "ind"); wr_a(0, 15, "ind0");
        ra = {AB'(0), AB'(9), AB'(3), AB'(17)};
        #1 check("ind p0", rd_rf[0 +: W], 100);
        check("ind p1", rd_rf[W +: W], 7);
        check("ind p2", rd_rf[2*W +: W], 8);
        check("ind p3", rd_wf[3*W +: W], 0);
        ra[AB +: AB] = 17;
        #1 check("ind p0 held", rd_rf[0 +: W], 100);
        check("ind p2 held", rd_rf[2*W +: W], 8);
        wr_a(6, 1, "byp_init");
        idle(); we_a = 1; wa_a = 6; da = 2; read_all(6);
        #1 check("byp wf pre", rd_wf[0 +: W], 2);
        check("byp rf pre", rd_rf[0 +: W], 1);
        step("byp");
        idle();
        #1 check("byp rf post", rd_rf[0 +: W], 2);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) set_rst(1);
            else if (rst) set_rst(0);
            we_a = 1'($urandom); we_b = 1'($urandom);
            wa_a = AB'($urandom_range(0, 7)); wa_b = AB'($urandom_range(0, 7));
            da = $urandom; db = $urandom;
            be_a = 4'($urandom); be_b = 4'($urandom);
            for (int i = 0; i < NR; i++) ra[i*AB +: AB] = AB'($urandom_range(0, 7));
            step("rand");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
